// File: rtl/cache_pkg.sv
// cache_pkg: controller state encoding and default cache geometry shared by the cache blocks
package cache_pkg;
    localparam int WAYS       = 8;
    localparam int INDEX_BITS = 14;
    localparam int TAG_BITS   = 10;
    localparam int LINE_SIZE  = 512;
    typedef enum logic [2:0] {
        IDLE, LOOKUP, COMPARE, MISS_REQ, MISS_WAIT, FILL, RESPOND
    } cache_state_t;
endpackage

// File: rtl/victim_select.sv
// victim_select: lowest invalid way wins; with a full set fall back to a round-robin pointer
module victim_select #(
    parameter int ways = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ways-1:0]           valid,
    input  logic                      advance,
    output logic [$clog2(ways)-1:0]   victim,
    output logic                      all_valid
);
    localparam int way_w = $clog2(ways);
    logic [way_w-1:0] ptr;
    always_ff @(posedge clk or posedge reset)
        if (reset)
            ptr <= '0;
        else if (advance)
            ptr <= (ptr == way_w'(ways - 1)) ? '0 : ptr + way_w'(1);
    always_comb begin
        victim = ptr;
        for (int i = ways - 1; i >= 0; i--)
            if (!valid[i]) victim = way_w'(i);
    end
    assign all_valid = &valid;
endmodule

// File: rtl/cache_controller.sv
// cache_controller: blocking lookup/fill controller for a set-associative cache
// with saturating hit/miss statistics.
module cache_controller
    import cache_pkg::*;
#(
    parameter int ways      = WAYS,
    parameter int indexBits = INDEX_BITS,
    parameter int tagBits   = TAG_BITS,
    parameter int lineSize  = LINE_SIZE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         reqValid,
    output logic                         reqReady,
    input  logic [tagBits+indexBits-1:0] reqAddress,
    output logic                         arrayRead,
    output logic [indexBits-1:0]         arrayIndex,
    input  logic [ways-1:0]              arrayValid,
    input  logic                         hit,
    input  logic [lineSize-1:0]          cacheLine,
    output logic                         memReqValid,
    input  logic                         memReqReady,
    output logic [tagBits+indexBits-1:0] memReqAddress,
    input  logic                         memRespValid,
    input  logic [lineSize-1:0]          memRespData,
    output logic                         arrayWrite,
    output logic [$clog2(ways)-1:0]      arrayWriteWay,
    output logic [tagBits-1:0]           arrayWriteTag,
    output logic [lineSize-1:0]          arrayWriteData,
    output logic                         respValid,
    input  logic                         respReady,
    output logic [lineSize-1:0]          respData,
    output logic                         respHit,
    output logic [31:0]                  hitCount,
    output logic [31:0]                  missCount
);
    localparam int way_w = $clog2(ways);
    cache_state_t state, state_n;
    logic [tagBits+indexBits-1:0] addr_q;
    logic [lineSize-1:0] line_q;
    logic [way_w-1:0] victim, victim_q;
    logic all_valid, victim_full_q, hit_q;

    victim_select #(.ways(ways)) u_victim (
        .clk      (clk),
        .reset    (reset),
        .valid    (arrayValid),
        .advance  (state == FILL && victim_full_q),
        .victim   (victim),
        .all_valid(all_valid)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (reqValid) state_n = LOOKUP;
            LOOKUP:    state_n = COMPARE;
            COMPARE:   state_n = hit ? RESPOND : MISS_REQ;
            MISS_REQ:  if (memReqReady) state_n = MISS_WAIT;
            MISS_WAIT: if (memRespValid) state_n = FILL;
            FILL:      state_n = RESPOND;
            RESPOND:   if (respReady) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // line_q carries the hit line or the fill line, so it feeds both the write port and the response
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            addr_q        <= '0;
            line_q        <= '0;
            victim_q      <= '0;
            victim_full_q <= 1'b0;
            hit_q         <= 1'b0;
            hitCount      <= '0;
            missCount     <= '0;
        end else begin
            if (state == IDLE && reqValid) addr_q <= reqAddress;
            if (state == COMPARE) begin
                hit_q <= hit;
                if (hit) begin
                    line_q <= cacheLine;
                    if (hitCount != '1) hitCount <= hitCount + 32'd1;
                end else begin
                    victim_q      <= victim;
                    victim_full_q <= all_valid;
                    if (missCount != '1) missCount <= missCount + 32'd1;
                end
            end
            if (state == MISS_WAIT && memRespValid) line_q <= memRespData;
        end

    assign reqReady       = state == IDLE && !reset;
    assign arrayRead      = state == LOOKUP;
    assign arrayIndex     = addr_q[indexBits-1:0];
    assign memReqValid    = state == MISS_REQ;
    assign memReqAddress  = addr_q;
    assign arrayWrite     = state == FILL;
    assign arrayWriteWay  = victim_q;
    assign arrayWriteTag  = addr_q[tagBits+indexBits-1:indexBits];
    assign arrayWriteData = line_q;
    assign respValid      = state == RESPOND;
    assign respData       = line_q;
    assign respHit        = hit_q;
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: randomized scenarios against a set/way array model and a saturating counter model
module tb_cache_controller;
    localparam int W = 8, IB = 14, TB = 10, LS = 512;

    logic clk = 1'b0, reset = 1'b1;
    logic reqValid = 1'b0, reqReady;
    logic [TB+IB-1:0] reqAddress = '0;
    logic arrayRead;
    logic [IB-1:0] arrayIndex;
    logic [W-1:0] arrayValid;
    logic hit;
    logic [LS-1:0] cacheLine;
    logic memReqValid, memReqReady = 1'b0;
    logic [TB+IB-1:0] memReqAddress;
    logic memRespValid = 1'b0;
    logic [LS-1:0] memRespData = '0;
    logic arrayWrite;
    logic [2:0] arrayWriteWay;
    logic [TB-1:0] arrayWriteTag;
    logic [LS-1:0] arrayWriteData;
    logic respValid, respReady = 1'b0, respHit;
    logic [LS-1:0] respData;
    logic [31:0] hitCount, missCount;

    int tests = 0, fails = 0, excl_viol = 0, wr_cnt = 0, m_ptr = 0;
    logic [31:0] exp_hitc = '0, exp_missc = '0;
    logic [TB-1:0] cur_tag = '0;
    logic [TB-1:0] m_tag [int];
    logic [LS-1:0] m_data [int];
    logic [2:0] obs_way;
    logic [LS-1:0] obs_data;

    cache_controller dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddress(reqAddress),
        .arrayRead(arrayRead), .arrayIndex(arrayIndex), .arrayValid(arrayValid),
        .hit(hit), .cacheLine(cacheLine),
        .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddress(memReqAddress),
        .memRespValid(memRespValid), .memRespData(memRespData),
        .arrayWrite(arrayWrite), .arrayWriteWay(arrayWriteWay), .arrayWriteTag(arrayWriteTag),
        .arrayWriteData(arrayWriteData),
        .respValid(respValid), .respReady(respReady), .respData(respData), .respHit(respHit),
        .hitCount(hitCount), .missCount(missCount)
    );

    always #5 clk = ~clk;

    function automatic logic [LS-1:0] rand_line();
        logic [LS-1:0] l;
        for (int i = 0; i < LS / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    // A way is valid exactly when the model holds a tag for it
    function automatic void lookup(input logic [TB-1:0] t, input int idx, output bit h,
                                   output logic [LS-1:0] d, output logic [W-1:0] vv);
        h = 1'b0; d = '0; vv = '0;
        for (int w = 0; w < W; w++)
            if (m_tag.exists(idx * W + w)) begin
                vv[w] = 1'b1;
                if (m_tag[idx * W + w] == t) begin h = 1'b1; d = m_data[idx * W + w]; end
            end
    endfunction

    // Tag/data array plus hit detector: answers one cycle after each arrayRead
    initial begin
        bit h;
        logic [LS-1:0] d;
        logic [W-1:0] vv;
        int lk_idx;
        arrayValid = '0; hit = 1'b0; cacheLine = '0;
        forever begin
            @(negedge clk);
            if (arrayRead === 1'b1) begin
                lk_idx = int'(arrayIndex);
                @(posedge clk); #1;
                lookup(cur_tag, lk_idx, h, d, vv);
                hit = h; cacheLine = h ? d : rand_line(); arrayValid = vv;
                @(posedge clk); #1;
                hit = 1'($urandom); cacheLine = rand_line(); arrayValid = 8'($urandom);
            end
        end
    end

    always @(negedge clk) begin
        if ($countones({arrayRead, arrayWrite, memReqValid}) > 1) excl_viol++;
        if (arrayWrite === 1'b1) wr_cnt++;
    end

    task automatic run_req(input logic [TB-1:0] tag, input int idx, input int mem_delay,
                           input int resp_delay, input bit busy, input logic [LS-1:0] fill);
        bit eh;
        logic [LS-1:0] ed;
        logic [W-1:0] vv;
        int vic, md;
        lookup(tag, idx, eh, ed, vv);
        cur_tag = tag;
        @(negedge clk); reqValid = 1'b1; reqAddress = {tag, IB'(idx)};
        tests++; if (reqReady !== 1'b1) begin fails++; $display("FAIL req_ready got %b exp 1", reqReady); end
        @(negedge clk); reqValid = 1'b0;
        tests++; if ({arrayRead, arrayIndex} !== {1'b1, IB'(idx)}) begin
            fails++; $display("FAIL lookup got rd=%b idx=%0d exp rd=1 idx=%0d", arrayRead, arrayIndex, idx);
        end
        @(negedge clk);
        tests++; if ({respValid, memReqValid} !== 2'b00) begin
            fails++; $display("FAIL compare_quiet got valid=%b memreq=%b exp 0 0", respValid, memReqValid);
        end
        if (eh) begin
            exp_hitc = sat_inc(exp_hitc);
            @(negedge clk);
        end else begin
            exp_missc = sat_inc(exp_missc);
            vic = -1;
            for (int w = 0; w < W; w++) if (!vv[w] && vic < 0) vic = w;
            if (vic < 0) begin vic = m_ptr; m_ptr = (m_ptr + 1) % W; end
            @(negedge clk);
            tests++; if ({memReqValid, memReqAddress} !== {1'b1, tag, IB'(idx)}) begin
                fails++; $display("FAIL mem_req got v=%b a=%h exp v=1 a=%h", memReqValid, memReqAddress, {tag, IB'(idx)});
            end
            repeat (mem_delay) begin
                reqValid = busy; memRespValid = busy; memRespData = rand_line();
                @(negedge clk);
                tests++; if ({memReqValid, memReqAddress, reqReady, arrayWrite} !== {1'b1, tag, IB'(idx), 2'b00}) begin
                    fails++; $display("FAIL mem_hold got v=%b a=%h rdy=%b wr=%b exp v=1 a=%h rdy=0 wr=0",
                                      memReqValid, memReqAddress, reqReady, arrayWrite, {tag, IB'(idx)});
                end
            end
            reqValid = 1'b0; memRespValid = 1'b0; memReqReady = 1'b1;
            @(negedge clk); memReqReady = 1'b0;
            tests++; if (memReqValid !== 1'b0) begin fails++; $display("FAIL mem_req_drop got %b exp 0", memReqValid); end
            md = $urandom_range(0, 3);
            repeat (md) @(negedge clk);
            memRespValid = 1'b1; memRespData = fill;
            @(negedge clk); memRespValid = 1'b0; memRespData = rand_line();
            tests++; if ({arrayWrite, arrayWriteWay, arrayWriteTag} !== {1'b1, 3'(vic), tag} || arrayWriteData !== fill) begin
                fails++; $display("FAIL fill got wr=%b way=%0d tag=%h exp wr=1 way=%0d tag=%h (data %s)",
                                  arrayWrite, arrayWriteWay, arrayWriteTag, vic, tag, arrayWriteData === fill ? "ok" : "wrong");
            end
            obs_way = arrayWriteWay;
            m_tag[idx * W + vic] = tag; m_data[idx * W + vic] = fill; ed = fill;
            @(negedge clk);
        end
        tests++; if ({respValid, respHit} !== {1'b1, eh} || respData !== ed) begin
            fails++; $display("FAIL resp got v=%b hit=%b d=%h exp v=1 hit=%b d=%h", respValid, respHit, respData, eh, ed);
        end
        obs_data = respData;
        repeat (resp_delay) begin
            reqValid = busy; reqAddress = 24'($urandom);
            @(negedge clk);
            tests++; if ({respValid, respHit, reqReady} !== {1'b1, eh, 1'b0} || respData !== ed) begin
                fails++; $display("FAIL resp_hold got v=%b hit=%b rdy=%b exp v=1 hit=%b rdy=0", respValid, respHit, reqReady, eh);
            end
        end
        respReady = 1'b1; reqValid = 1'b0;
        @(negedge clk); respReady = 1'b0;
        tests++; if ({respValid, reqReady} !== 2'b01 || hitCount !== exp_hitc || missCount !== exp_missc) begin
            fails++; $display("FAIL done got v=%b rdy=%b hits=%h misses=%h exp v=0 rdy=1 hits=%h misses=%h",
                              respValid, reqReady, hitCount, missCount, exp_hitc, exp_missc);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++; if ({reqReady, arrayRead, arrayWrite, memReqValid, respValid, respHit} !== 6'b0) begin
            fails++; $display("FAIL reset_ctrl got %b exp 000000", {reqReady, arrayRead, arrayWrite, memReqValid, respValid, respHit});
        end
        tests++; if (hitCount !== 0 || missCount !== 0 || respData !== '0 || memReqAddress !== '0) begin
            fails++; $display("FAIL reset_data got hits=%h misses=%h addr=%h exp 0", hitCount, missCount, memReqAddress);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++; if (reqReady !== 1'b1) begin fails++; $display("FAIL reset_release got rdy=%b exp 1", reqReady); end
    endtask

    task automatic test_hit;
        logic [LS-1:0] line;
        line = rand_line();
        m_tag[5 * W + 3] = 10'h2A; m_data[5 * W + 3] = line;
        run_req(10'h2A, 5, 0, 0, 1'b0, '0);
        tests++; if (hitCount !== 32'd1 || obs_data !== line) begin
            fails++; $display("FAIL hit_line got hits=%0d exp 1 (data %s)", hitCount, obs_data === line ? "ok" : "wrong");
        end
    endtask

    task automatic test_miss_invalid;
        for (int w = 0; w < W; w++)
            if (w != 3) begin m_tag[7 * W + w] = 10'h100 + 10'(w); m_data[7 * W + w] = rand_line(); end
        run_req(10'h11, 7, 1, 1, 1'b0, {64{8'hAB}});
        tests++; if (obs_way !== 3'd3 || missCount !== 32'd1 || obs_data !== {64{8'hAB}}) begin
            fails++; $display("FAIL miss_invalid got way=%0d misses=%0d exp way=3 misses=1", obs_way, missCount);
        end
    endtask

    task automatic test_round_robin;
        for (int w = 0; w < W; w++) begin m_tag[9 * W + w] = 10'h200 + 10'(w); m_data[9 * W + w] = rand_line(); end
        for (int i = 0; i < 9; i++) begin
            run_req(10'h300 + 10'(i), 9, $urandom_range(0, 2), 0, 1'b0, rand_line());
            tests++; if (obs_way !== 3'(i % W)) begin
                fails++; $display("FAIL rr_way[%0d] got %0d exp %0d", i, obs_way, i % W);
            end
        end
    endtask

    task automatic test_backpressure;
        run_req(10'h155, 11, 10, 5, 1'b1, rand_line());
        run_req(10'h155, 11, 0, 5, 1'b1, '0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++)
            run_req(10'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 3),
                    $urandom_range(0, 2), 1'($urandom), rand_line());
    endtask

    task automatic test_saturation;
        @(negedge clk);
        force dut.hitCount = 32'hFFFF_FFFE;
        force dut.missCount = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.hitCount;
        release dut.missCount;
        exp_hitc = 32'hFFFF_FFFE; exp_missc = 32'hFFFF_FFFE;
        @(negedge clk);
        tests++; if (hitCount !== 32'hFFFF_FFFE) begin fails++; $display("FAIL sat_preset got %h exp fffffffe", hitCount); end
        for (int i = 0; i < 2; i++) begin
            run_req(10'h2A, 5, 0, 0, 1'b0, '0);
            tests++; if (hitCount !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_hit[%0d] got %h exp ffffffff", i, hitCount); end
        end
        for (int i = 0; i < 2; i++) begin
            run_req(10'h3F0 + 10'(i), 100, 0, 0, 1'b0, rand_line());
            tests++; if (missCount !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_miss[%0d] got %h exp ffffffff", i, missCount); end
        end
    endtask

    task automatic test_reset_mid_miss;
        int wr0;
        cur_tag = 10'h3FF;
        @(negedge clk); reqValid = 1'b1; reqAddress = {10'h3FF, 14'd101};
        @(negedge clk); reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk); memReqReady = 1'b1;
        tests++; if (memReqValid !== 1'b1) begin fails++; $display("FAIL abandon_req got %b exp 1", memReqValid); end
        @(negedge clk); memReqReady = 1'b0;
        wr0 = wr_cnt;
        #2 reset = 1'b1;
        #1;
        tests++; if ({reqReady, memReqValid, arrayWrite, respValid, arrayRead} !== 5'b0 || hitCount !== 0 || missCount !== 0) begin
            fails++; $display("FAIL async_reset got ctl=%b hits=%h misses=%h exp 0",
                              {reqReady, memReqValid, arrayWrite, respValid, arrayRead}, hitCount, missCount);
        end
        @(negedge clk); reset = 1'b0;
        m_ptr = 0; exp_hitc = '0; exp_missc = '0;
        memRespValid = 1'b1; memRespData = rand_line();
        @(negedge clk); memRespValid = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (wr_cnt !== wr0 || {reqReady, respValid, memReqValid} !== 3'b100) begin
            fails++; $display("FAIL stale_resp got writes=%0d rdy=%b v=%b mreq=%b exp writes=%0d rdy=1 v=0 mreq=0",
                              wr_cnt, reqReady, respValid, memReqValid, wr0);
        end
        run_req(10'h3FF, 101, 0, 0, 1'b0, rand_line());
    endtask

    task automatic test_exclusive;
        tests++; if (excl_viol !== 0) begin fails++; $display("FAIL strobe_overlap got %0d cycles exp 0", excl_viol); end
    endtask

    initial begin
        test_reset;
        test_hit;
        test_miss_invalid;
        test_round_robin;
        test_backpressure;
        test_random;
        test_saturation;
        test_reset_mid_miss;
        test_exclusive;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
